// File: rtl/stud_audiodac_pkg.sv
// Shared constants and helpers for the audio DAC front end.
package stud_audiodac_pkg;

  localparam int unsigned DEF_BITWIDTH            = 16;
  localparam int unsigned DEF_FIFO_DEPTH_LOG2     = 3;
  localparam int unsigned DEF_CLK_PER_SAMPLE_LOG2 = 9;

  // Midscale code of an unsigned offset-binary word of the given width.
  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/stud_audio_sample_feeder_if.sv
// Sample stream, mute control and status bundle between the audio source and the feeder.
interface stud_audio_sample_feeder_if
  import stud_audiodac_pkg::*;
#(
  parameter int unsigned BITWIDTH        = DEF_BITWIDTH,
  parameter int unsigned FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2
);

  logic [BITWIDTH-1:0]      data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic                     mute_i;
  logic [BITWIDTH-1:0]      data_o;
  logic                     underflow_o;
  logic [FIFO_DEPTH_LOG2:0] fill_o;

  modport master (
    output data_i, valid_i, mute_i,
    input  ready_o, data_o, underflow_o, fill_o
  );

  modport slave (
    input  data_i, valid_i, mute_i,
    output ready_o, data_o, underflow_o, fill_o
  );

endinterface

// File: rtl/stud_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible combinationally.
module stud_sync_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_c_o,
  output logic                  full_c_o,
  output logic                  empty_c_o,
  output logic [DEPTH_LOG2:0]   fill_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  do_push, do_pop;

  // Status flags and qualified push/pop (no overwrite when full, no read when empty).
  always_comb begin
    full_c_o  = (fill_q == FILL_W'(DEPTH));
    empty_c_o = (fill_q == '0);
    do_push   = push_i && !full_c_o;
    do_pop    = pop_i && !empty_c_o;
    head_c_o  = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy next-state; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO logically.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/stud_audio_sample_feeder.sv
// Buffers signed audio samples and presents one offset-binary sample per audio
// period to the delta-sigma modulator, with underflow hold and mute.
// Optional build macro STUD_LINEAR_INTERP_EN replaces the zero-order hold with a
// linear ramp from the previous sample to the newly popped one.
module stud_audio_sample_feeder
  import stud_audiodac_pkg::*;
#(
  parameter int unsigned BITWIDTH            = DEF_BITWIDTH,
  parameter int unsigned FIFO_DEPTH_LOG2     = DEF_FIFO_DEPTH_LOG2,
  parameter int unsigned CLK_PER_SAMPLE_LOG2 = DEF_CLK_PER_SAMPLE_LOG2
) (
  input  logic                       clk_i,
  input  logic                       n_rst_i,
  stud_audio_sample_feeder_if.slave  feed_if
);

  localparam int unsigned MSB = BITWIDTH - 1;
  localparam logic [BITWIDTH-1:0] MIDSCALE = BITWIDTH'(midscale(BITWIDTH));

  logic [CLK_PER_SAMPLE_LOG2-1:0] tick_cnt_q, tick_cnt_d;
  logic                           tick_c;
  logic [BITWIDTH-1:0]            head_c;
  logic                           full_c, empty_c;
  logic [FIFO_DEPTH_LOG2:0]       fill;
  logic                           push_c, pop_c;
  logic [BITWIDTH-1:0]            held_q, held_d;
  logic [BITWIDTH-1:0]            sample_c;
  logic [BITWIDTH-1:0]            data_q, data_d;
  logic                           underflow_q, underflow_d;

  stud_sync_fifo #(
    .WIDTH      (BITWIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk_i),
    .n_rst_i   (n_rst_i),
    .push_i    (push_c),
    .wdata_i   (feed_if.data_i),
    .pop_i     (pop_c),
    .head_c_o  (head_c),
    .full_c_o  (full_c),
    .empty_c_o (empty_c),
    .fill_o    (fill)
  );

  // Free-running sample-period counter; the all-ones state is the tick.
  always_comb begin
    tick_cnt_d = tick_cnt_q + CLK_PER_SAMPLE_LOG2'(1);
    tick_c     = &tick_cnt_q;
  end

  // FIFO handshake, pop on tick, and the held (most recently popped) sample.
  always_comb begin
    push_c      = feed_if.valid_i && !full_c;
    pop_c       = tick_c && !empty_c;
    held_d      = pop_c ? head_c : held_q;
    underflow_d = tick_c && empty_c;
  end

`ifdef STUD_LINEAR_INTERP_EN
  localparam int unsigned ACC_W = BITWIDTH + CLK_PER_SAMPLE_LOG2 + 1;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BITWIDTH:0]   delta_q, delta_d;

  // Ramp: restart from the previous sample at each tick, add the step every clock.
  always_comb begin
    acc_d   = acc_q + {{CLK_PER_SAMPLE_LOG2{delta_q[BITWIDTH]}}, delta_q};
    delta_d = delta_q;
    if (tick_c) begin
      acc_d   = {held_q[MSB], held_q, {CLK_PER_SAMPLE_LOG2{1'b0}}};
      delta_d = {held_d[MSB], held_d} - {held_q[MSB], held_q};
    end
    sample_c = acc_d[CLK_PER_SAMPLE_LOG2 +: BITWIDTH];
  end

  // Interpolator state.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      acc_q   <= '0;
      delta_q <= '0;
    end else begin
      acc_q   <= acc_d;
      delta_q <= delta_d;
    end
  end
`else
  // Zero-order hold: the output follows the held sample directly.
  always_comb begin
    sample_c = held_d;
  end
`endif

  // Offset-binary conversion with mute override; mute_i is registered once here.
  always_comb begin
    data_d = feed_if.mute_i ? MIDSCALE : {~sample_c[MSB], sample_c[MSB-1:0]};
  end

  // Main state registers; reset drives midscale out immediately.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      tick_cnt_q  <= '0;
      held_q      <= '0;
      data_q      <= MIDSCALE;
      underflow_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      held_q      <= held_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign feed_if.data_o      = data_q;
  assign feed_if.underflow_o = underflow_q;
  assign feed_if.fill_o      = fill;
  assign feed_if.ready_o     = !full_c;

endmodule

// File: doc/stud_audio_sample_feeder.md
Name: stud_audio_sample_feeder

Overview:
- Upstream stage of the second-order delta-sigma modulator: buffers signed audio samples arriving on a valid/ready interface in a small FIFO.
- Pops one sample per audio sample period, converts two's complement to offset binary and holds the result for the modulator's unsigned data input.
- Handles underflow and mute so the modulator never sees an undefined or stale-garbage input.

Parameters:
- BITWIDTH, 16, audio sample width (input and output).
- FIFO_DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).
- CLK_PER_SAMPLE_LOG2, 9, log2 of clocks per audio sample period (512 = 4 clocks per modulator sample x 128 oversampling).

Ports:
- clk_i  input  1  clock.
- n_rst_i  input  1  reset, asynchronous assertion, active low.
- data_i  input  BITWIDTH  audio sample, signed two's complement.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept a sample.
- mute_i  input  1  force midscale output.
- data_o  output  BITWIDTH  unsigned offset-binary sample to the modulator.
- underflow_o  output  1  one-cycle pulse: sample tick found the FIFO empty.
- fill_o  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (n_rst_i low, asynchronous): FIFO pointers and fill = 0, tick counter = 0, held sample = 0, data_o = 2^(BITWIDTH-1) (0x8000 for defaults), underflow_o = 0. Release is synchronised by the existing reset scheme; no internal synchroniser.
- ready_o = (fill_o != 2^FIFO_DEPTH_LOG2); combinational from registered fill, not from valid_i.
- Push: valid_i && ready_o writes data_i at the write pointer on the rising edge.
- Pointers are FIFO_DEPTH_LOG2 bits and wrap naturally; fill tracks occupancy.
- Tick counter: free-running, CLK_PER_SAMPLE_LOG2 bits, wraps. Tick is asserted when the counter is all ones, so the first tick occurs 2^CLK_PER_SAMPLE_LOG2 cycles after reset release.
- On tick with fill != 0:
  - pop the head into the held sample;
  - data_o updates on the next edge, so latency from tick to data_o is 1 cycle.
- On tick with fill == 0:
  - no pop; held sample unchanged (repeat last sample);
  - underflow_o = 1 for exactly one cycle.
- Push and pop in the same cycle: both happen, fill unchanged.
- Push into empty FIFO on a tick cycle: the pop sees empty (underflow), the sample is stored and popped at the next tick.
- Full: ready_o = 0 and any valid_i is ignored; no overwrite and no flag.
- data_o = mute_i_reg ? 2^(BITWIDTH-1) : {~held[MSB], held[MSB-1:0]}.
  - mute_i is registered once, so data_o reacts 1 cycle after mute_i changes.
  - The FIFO continues to pop while muted.
- Output is registered: data_o changes only on the tick+1 cycle or on a mute transition, never mid-period otherwise.
- Mid-operation reset clears the FIFO contents logically (pointers) and returns data_o to midscale immediately.

Optional Feature:
- Macro: STUD_LINEAR_INTERP_EN.
- Defined: linear interpolation between the previous held sample and the newly popped sample.
  - Accumulator is BITWIDTH+CLK_PER_SAMPLE_LOG2+1 bits, signed.
  - At tick: accumulator = previous sample << CLK_PER_SAMPLE_LOG2, and delta = new - previous (BITWIDTH+1 bits, signed).
  - Each cycle: accumulator += delta.
  - data_o = offset-binary of the accumulator's upper BITWIDTH bits, so the ramp reaches the new sample exactly at the next tick.
  - Adds one sample period of latency.
  - Underflow sets delta = 0.
  - Mute bypasses the ramp and outputs midscale.
- Undefined: zero-order hold as described above.

Decomposition:
- Shared package stud_audiodac_pkg:
  - midscale constant function of BITWIDTH;
  - default CLK_PER_SAMPLE_LOG2 = 9;
  - default FIFO_DEPTH_LOG2 = 3.
- One natural sub-module: stud_sync_fifo (parameterised width/depth; push/pop/full/empty/fill; asynchronous active-low reset).
- Tick counter, offset conversion and interpolator live in the top module.

Test Plan:
- Reset then idle, valid_i = 0: data_o = 0x8000 throughout; underflow_o pulses once every 512 cycles; ready_o = 1; fill_o = 0.
- Push 0x7FFF, then 0x8000, then 0x0000:
  - data_o = 0xFFFF, then 0x0000, then 0x8000;
  - each value appears 1 cycle after successive ticks;
  - no underflow during those three ticks.
- Push 9 samples back-to-back with no tick:
  - ready_o falls after the 8th;
  - the 9th is dropped and fill_o = 8;
  - after the 8 pops, the outputs equal the first 8 samples in order.
- Push coincident with a tick on an empty FIFO: underflow_o = 1 in that tick; fill_o = 1 afterwards; the sample appears on data_o after the following tick.
- Set mute_i = 1 mid-stream with sample 0x1234 held:
  - data_o = 0x8000 one cycle later;
  - fill_o keeps decrementing at ticks;
  - release mute: data_o shows the current sample's offset-binary value.
- With STUD_LINEAR_INTERP_EN, step from 0x0000 to 0x0100:
  - data_o rises monotonically, 1 LSB every 2 cycles;
  - offset-binary data_o reaches 0x8100 exactly at the next tick.
- Also: assert n_rst_i low mid-stream → data_o = 0x8000 and fill_o = 0 without waiting for a clock edge.
